fb_swap_ctrl: RTL and testbench

//  Double-buffer sequencer for vga_out frame buffers A/B. Grants the renderer exclusive write access
//  to the back buffer, waits for render_done, swaps front/back at the frame boundary (tear-free).

---
 rtl/fb_swap_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fb_swap_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_swap_ctrl.sv
// -----------------------------------------------------------------------------
// fb_swap_ctrl
// Double-buffer sequencer that sits between the game/draw logic and vga_out.
// vga_out scans out the "front" frame buffer (A or B). The renderer may only
// write the other one, the "back" buffer, and only while render_grant is high.
// When the renderer signals render_done, the controller waits for the frame
// boundary and swaps front and back on that edge, so a frame is never shown
// half old and half new. If a render does not finish within TIMEOUT_FRM frame
// ends, the grant is withdrawn and render_abort pulses. Every frame end that
// does not swap is counted as a repeated frame.
//
// Parameters
//   HCOUNT_MAX   last hcount value of a line
//   VCOUNT_MAX   last vcount value of a frame
//   TIMEOUT_FRM  frame ends allowed while granted before abort (1..15)
//
// Ports
//   clk           pixel clock, all logic on the rising edge
//   rst_n         asynchronous, active-low reset
//   hcount        horizontal counter from the timing generator
//   vcount        vertical counter from the timing generator
//   render_req    renderer asks for a new frame (level, sampled in IDLE)
//   render_done   one-cycle pulse: back buffer is complete
//   render_grant  renderer may write the back buffer
//   render_abort  one-cycle pulse: render timed out, grant withdrawn
//   front_sel     buffer scanned out by vga_out (0 = A, 1 = B)
//   frame_ready   one-cycle pulse on the cycle after every frame end
//   swap_pending  finished frame is waiting for the frame boundary
//   repeat_cnt    saturating count of frame ends that did not swap
// -----------------------------------------------------------------------------
module fb_swap_ctrl #(
   parameter int HCOUNT_MAX  = 1055,
   parameter int VCOUNT_MAX  = 627,
   parameter int TIMEOUT_FRM = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] hcount,
   input  logic [10:0] vcount,
   input  logic        render_req,
   input  logic        render_done,
   output logic        render_grant,
   output logic        render_abort,
   output logic        front_sel,
   output logic        frame_ready,
   output logic        swap_pending,
   output logic [7:0]  repeat_cnt
);

   localparam logic [10:0] H_LAST      = 11'(HCOUNT_MAX);
   localparam logic [10:0] V_LAST      = 11'(VCOUNT_MAX);
   localparam logic [3:0]  TIMEOUT_VAL = 4'(TIMEOUT_FRM);
   localparam logic [7:0]  REPEAT_MAX  = 8'hFF;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      GRANTED   = 2'd1,
      WAIT_SWAP = 2'd2
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [3:0] timer;
   logic [3:0] timer_next;
   logic       abort_next;
   logic       swap_now;
   logic       frame_end;

   // The last pixel of the frame. Only an exact match counts, so counter
   // values outside the visible/blanking range can never fake a boundary.
   assign frame_end = (hcount == H_LAST) && (vcount == V_LAST);

   // Moore outputs decoded straight from the registered state.
   assign render_grant = (state == GRANTED);
   assign swap_pending = (state == WAIT_SWAP);

   // Next-state logic. A render_done that lands on the frame-end cycle moves
   // to WAIT_SWAP without swapping: the buffer could still be mid-write on
   // that cycle, so the swap is deferred to the following frame end and the
   // timeout timer is left alone. render_req and render_done are only looked
   // at in the states where they mean something and are otherwise ignored.
   always_comb begin
      state_next = state;
      timer_next = timer;
      abort_next = 1'b0;
      swap_now   = 1'b0;
      case (state)
         IDLE: begin
            timer_next = 4'd0;
            if (render_req) begin
               state_next = GRANTED;
            end
         end
         GRANTED: begin
            if (render_done) begin
               state_next = WAIT_SWAP;
            end else if (frame_end) begin
               if (timer + 4'd1 == TIMEOUT_VAL) begin
                  state_next = IDLE;
                  timer_next = 4'd0;
                  abort_next = 1'b1;
               end else begin
                  timer_next = timer + 4'd1;
               end
            end
         end
         WAIT_SWAP: begin
            if (frame_end) begin
               swap_now   = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            timer_next = 4'd0;
         end
      endcase
   end

   // State register and timeout timer. Reset drops any render in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         timer <= 4'd0;
      end else begin
         state <= state_next;
         timer <= timer_next;
      end
   end

   // Front buffer select. It flips only on the frame-end edge so vga_out
   // starts the new buffer exactly at pixel (0,0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         front_sel <= 1'b0;
      end else if (swap_now) begin
         front_sel <= ~front_sel;
      end
   end

   // One-cycle strobes: frame_ready follows every frame end, render_abort
   // follows the frame end that exhausted the render budget.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_ready  <= 1'b0;
         render_abort <= 1'b0;
      end else begin
         frame_ready  <= frame_end;
         render_abort <= abort_next;
      end
   end

   // Repeated-frame counter. Any frame end without a swap (idle, still
   // rendering, aborting, or a done that arrived on the boundary itself)
   // shows the same image again. Holds at 255 instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         repeat_cnt <= 8'd0;
      end else if (frame_end && !swap_now && (repeat_cnt != REPEAT_MAX)) begin
         repeat_cnt <= repeat_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fb_swap_ctrl
// Testbench for fb_swap_ctrl with a shrunken frame (8x8 pixels) so that
// hundreds of frames fit in a short run. The bench plays the timing generator
// and the renderer, keeps a rule-level model of what the controller should
// show, and also keeps two small frame buffers that the renderer writes while
// granted, so the displayed buffer content can be compared with the render
// that should be on screen.
// -----------------------------------------------------------------------------
module tb_fb_swap_ctrl;

   localparam int H  = 7;
   localparam int V  = 7;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] hcount = 11'd0;
   logic [10:0] vcount = 11'd0;
   logic        render_req = 1'b0;
   logic        render_done = 1'b0;
   logic        render_grant;
   logic        render_abort;
   logic        front_sel;
   logic        frame_ready;
   logic        swap_pending;
   logic [7:0]  repeat_cnt;

   int checks = 0;
   int failures = 0;

   // Rule-level model of the controller.
   bit m_granted, m_waiting, m_abort, m_ready, m_front;
   int m_repeat, m_frames;

   // Renderer side: two frame buffers holding the id of the render that last
   // wrote them, the render currently being drawn, the finished one awaiting
   // display and the one that should be on screen.
   int fb_mem [2];
   int cur_id, pending_id, shown_id;

   fb_swap_ctrl #(
      .HCOUNT_MAX (H),
      .VCOUNT_MAX (V),
      .TIMEOUT_FRM(TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hcount      (hcount),
      .vcount      (vcount),
      .render_req  (render_req),
      .render_done (render_done),
      .render_grant(render_grant),
      .render_abort(render_abort),
      .front_sel   (front_sel),
      .frame_ready (frame_ready),
      .swap_pending(swap_pending),
      .repeat_cnt  (repeat_cnt)
   );

   always #5 clk = ~clk;

   // Clears the model and the renderer bookkeeping, as a reset does.
   task automatic model_reset();
      m_granted  = 0;
      m_waiting  = 0;
      m_abort    = 0;
      m_ready    = 0;
      m_front    = 0;
      m_repeat   = 0;
      m_frames   = 0;
      fb_mem[0]  = 0;
      fb_mem[1]  = 0;
      cur_id     = 0;
      pending_id = 0;
      shown_id   = 0;
   endtask

   // Applies the controller's rules for one clock edge given the inputs
   // presented during the cycle before it.
   task automatic model_edge(input bit fe, input bit req, input bit done);
      bit swap;
      swap    = m_waiting && fe;
      m_ready = fe;
      m_abort = 0;
      if (fe && !swap && m_repeat < 255) m_repeat++;
      if (swap) begin
         m_front   = !m_front;
         shown_id  = pending_id;
         m_waiting = 0;
      end else if (m_granted) begin
         if (done) begin
            m_granted  = 0;
            m_waiting  = 1;
            pending_id = cur_id;
         end else if (fe) begin
            m_frames++;
            if (m_frames == TO) begin
               m_granted = 0;
               m_abort   = 1;
            end
         end
      end else if (!m_waiting && req) begin
         m_granted = 1;
         m_frames  = 0;
      end
   endtask

   function automatic logic [12:0] model_vec();
      return {m_granted, m_abort, m_front, m_ready, m_waiting, 8'(m_repeat)};
   endfunction

   function automatic logic [12:0] dut_vec();
      return {render_grant, render_abort, front_sel, frame_ready, swap_pending, repeat_cnt};
   endfunction

   function automatic bit at_frame_end();
      return (int'(hcount) == H) && (int'(vcount) == V);
   endfunction

   // One clock: model the edge, wait for it, let the renderer write its
   // back buffer, advance the raster position and end any done pulse.
   task automatic step();
      if (!rst_n) model_reset();
      else model_edge(at_frame_end(), render_req, render_done);
      @(posedge clk);
      #1;
      if (render_grant === 1'b1) fb_mem[!front_sel] = cur_id;
      if (int'(hcount) == H) begin
         hcount = 11'd0;
         vcount = (int'(vcount) == V) ? 11'd0 : vcount + 11'd1;
      end else begin
         hcount = hcount + 11'd1;
      end
      render_done = 1'b0;
   endtask

   // Steps until the raster reaches (h,v), bounded so a stuck run still ends.
   task automatic run_to(input int h, input int v);
      int n = 0;
      while (!((int'(hcount) == h) && (int'(vcount) == v)) && n < 200) begin
         step();
         n++;
      end
      checks++;
      if (n >= 200) begin
         failures++;
         $display("[TB] FAIL run_to position (%0d,%0d) not reached, at (%0d,%0d)", h, v, hcount, vcount);
      end
   endtask

   task automatic do_reset();
      render_req  = 1'b0;
      render_done = 1'b0;
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      checks++;
      if (dut_vec() !== 13'd0) begin
         failures++;
         $display("[TB] FAIL reset_initial got %b want %b", dut_vec(), 13'd0);
      end
      rst_n = 1'b1;
      render_req = 1'b1;
      step();
      render_req = 1'b0;
      repeat (5) step();
      checks++;
      if (render_grant !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_pre_grant got %b want 1", render_grant);
      end
      // Asynchronous reset mid-render clears everything without a clock edge.
      rst_n = 1'b0;
      #1;
      checks++;
      if (dut_vec() !== 13'd0) begin
         failures++;
         $display("[TB] FAIL reset_async got %b want %b", dut_vec(), 13'd0);
      end
      repeat (3) step();
      rst_n = 1'b1;
      step();
      checks++;
      if (dut_vec() !== 13'd0) begin
         failures++;
         $display("[TB] FAIL reset_release got %b want %b", dut_vec(), 13'd0);
      end
   endtask

   task automatic test_single_render();
      $display("[TB] test_single_render");
      run_to(3, 1);
      render_req = 1'b1;
      cur_id = 11;
      step();
      render_req = 1'b0;
      checks++;
      if (render_grant !== 1'b1) begin
         failures++;
         $display("[TB] FAIL single_grant_latency got %b want 1", render_grant);
      end
      run_to(2, 5);
      render_done = 1'b1;
      step();
      checks++;
      if ({render_grant, swap_pending, front_sel} !== 3'b010) begin
         failures++;
         $display("[TB] FAIL single_after_done got %b want 010", {render_grant, swap_pending, front_sel});
      end
      run_to(H, V);
      checks++;
      if (front_sel !== 1'b0) begin
         failures++;
         $display("[TB] FAIL single_no_early_swap got %b want 0", front_sel);
      end
      step();
      checks++;
      if ({front_sel, frame_ready, swap_pending} !== 3'b110) begin
         failures++;
         $display("[TB] FAIL single_swap_edge got %b want 110", {front_sel, frame_ready, swap_pending});
      end
      step();
      checks++;
      if ({frame_ready, repeat_cnt} !== {1'b0, 8'd0}) begin
         failures++;
         $display("[TB] FAIL single_after_swap got %b/%0d want 0/0", frame_ready, repeat_cnt);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
         failures++;
         $display("[TB] FAIL single_model got %b want %b", dut_vec(), model_vec());
      end
   endtask

   task automatic test_coincident();
      logic [7:0] rep0;
      logic       front0;
      $display("[TB] test_coincident");
      render_req = 1'b1;
      step();
      render_req = 1'b0;
      run_to(H, V);
      rep0 = repeat_cnt;
      front0 = front_sel;
      render_done = 1'b1;
      step();
      checks++;
      if ({front_sel, swap_pending, repeat_cnt} !== {front0, 1'b1, rep0 + 8'd1}) begin
         failures++;
         $display("[TB] FAIL coincident_no_swap got %b/%b/%0d want %b/1/%0d",
                  front_sel, swap_pending, repeat_cnt, front0, rep0 + 8'd1);
      end
      run_to(H, V);
      step();
      checks++;
      if ({front_sel, swap_pending, repeat_cnt} !== {!front0, 1'b0, rep0 + 8'd1}) begin
         failures++;
         $display("[TB] FAIL coincident_next_swap got %b/%b/%0d want %b/0/%0d",
                  front_sel, swap_pending, repeat_cnt, !front0, rep0 + 8'd1);
      end
   endtask

   task automatic test_timeout();
      int aborts = 0;
      bit mismatch = 0;
      $display("[TB] test_timeout");
      rst_n = 1'b0;
      run_to(0, 1);
      rst_n = 1'b1;
      render_req = 1'b1;
      // Held request, no done: exactly one abort after the fourth frame end.
      while (aborts == 0 && !mismatch && m_frames < TO + 2) begin
         step();
         checks++;
         if (dut_vec() !== model_vec()) begin
            failures++;
            mismatch = 1;
            $display("[TB] FAIL timeout_model got %b want %b", dut_vec(), model_vec());
         end
         if (render_abort === 1'b1) aborts++;
      end
      checks++;
      if ({aborts == 1, front_sel, repeat_cnt, render_grant} !== {1'b1, 1'b0, 8'd4, 1'b0}) begin
         failures++;
         $display("[TB] FAIL timeout_abort aborts=%0d front=%b rep=%0d grant=%b want 1/0/4/0",
                  aborts, front_sel, repeat_cnt, render_grant);
      end
      step();
      checks++;
      if ({render_grant, render_abort} !== 2'b10) begin
         failures++;
         $display("[TB] FAIL timeout_regrant got %b want 10", {render_grant, render_abort});
      end
      render_req = 1'b0;
   endtask

   task automatic test_saturation();
      bit mismatch = 0;
      $display("[TB] test_saturation");
      do_reset();
      for (int i = 0; i < 300 * (H + 1) * (V + 1); i++) begin
         step();
         if (!mismatch && dut_vec() !== model_vec()) begin
            checks++;
            failures++;
            mismatch = 1;
            $display("[TB] FAIL saturation_model got %b want %b", dut_vec(), model_vec());
         end
      end
      checks++;
      if ({repeat_cnt, front_sel} !== {8'd255, 1'b0}) begin
         failures++;
         $display("[TB] FAIL saturation_end got %0d/%b want 255/0", repeat_cnt, front_sel);
      end
   endtask

   task automatic test_back_to_back();
      $display("[TB] test_back_to_back");
      do_reset();
      run_to(0, 0);
      for (int r = 1; r <= 3; r++) begin
         cur_id = r;
         render_req = 1'b1;
         step();
         render_req = 1'b0;
         run_to(2, 3);
         render_done = 1'b1;
         step();
         run_to(H, V);
         step();
         checks++;
         if (front_sel !== r[0]) begin
            failures++;
            $display("[TB] FAIL b2b_front render %0d got %b want %b", r, front_sel, r[0]);
         end
         checks++;
         if (fb_mem[front_sel] !== shown_id || shown_id != r) begin
            failures++;
            $display("[TB] FAIL b2b_buffer render %0d got %0d want %0d", r, fb_mem[front_sel], r);
         end
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
         failures++;
         $display("[TB] FAIL b2b_model got %b want %b", dut_vec(), model_vec());
      end
   endtask

   task automatic test_random();
      bit mismatch = 0;
      $display("[TB] test_random");
      do_reset();
      for (int i = 0; i < 60 * (H + 1) * (V + 1); i++) begin
         if (render_grant === 1'b0 && swap_pending === 1'b0) cur_id = 100 + i;
         render_req  = ($urandom_range(0, 9) < 3);
         render_done = ($urandom_range(0, 99) < 4);
         step();
         if (!mismatch) begin
            checks++;
            if (dut_vec() !== model_vec()) begin
               failures++;
               mismatch = 1;
               $display("[TB] FAIL random_model cycle %0d got %b want %b", i, dut_vec(), model_vec());
            end
            checks++;
            if (fb_mem[front_sel] !== shown_id) begin
               failures++;
               mismatch = 1;
               $display("[TB] FAIL random_buffer cycle %0d got %0d want %0d", i, fb_mem[front_sel], shown_id);
            end
         end
      end
      render_req = 1'b0;
   endtask

   initial begin
      model_reset();
      #1;
      test_reset();
      test_single_render();
      test_coincident();
      test_timeout();
      test_saturation();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
